// File: rtl/pipe_dbg_pkg.sv
// pipe_dbg_pkg: shared encodings and widths for the pipeline run/halt/step controller
package pipe_dbg_pkg;
  typedef enum logic [1:0] {
    RUN_S  = 2'b00,
    HALT_S = 2'b01,
    STEP_S = 2'b10
  } run_state_e;
  localparam int STEP_W_DEF = 8;
  localparam int CNT_W = 32;
  localparam int ADDR_W = 32;
endpackage

// File: rtl/pipe_bp_match.sv
// pipe_bp_match: PC breakpoint comparator with an armed flag that suppresses re-trigger after resume
module pipe_bp_match
  import pipe_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              resume,
  output logic              match
);
  logic armed_q, armed_d;
  // Stays disarmed while a stall holds the PC on the breakpoint address
  always_comb begin
    armed_d = resume ? 1'b0 : (if_pc != bp_addr) ? 1'b1 : armed_q;
  end
  assign match = bp_en && armed_q && (if_pc == bp_addr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed_q <= 1'b1;
    else armed_q <= armed_d;
  end
endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/halt/step/breakpoint controller driving the global pipeline freeze
module pipe_run_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int STEP_W       = STEP_W_DEF,
  parameter bit START_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              wb_valid,
  output logic              freeze,
  output logic              halted,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);
  localparam run_state_e RST_S = START_HALTED ? HALT_S : RUN_S;
  run_state_e state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d;
  logic freeze_q, bp_hit_q, bp_hit_d, retire, resume, match;
  pipe_bp_match u_bp (
    .clk(clk), .rst(rst), .bp_en(bp_en), .bp_addr(bp_addr),
    .if_pc(if_pc), .resume(resume), .match(match)
  );
  always_comb begin
    retire = !freeze_q && wb_valid;
    state_d = state_q;
    bp_hit_d = 1'b0;
    case (state_q)
      RUN_S: begin
        if (halt_req) state_d = HALT_S;
        else if (match) begin
          state_d = HALT_S;
          bp_hit_d = 1'b1;
        end
      end
      HALT_S: begin
        if (halt_req) state_d = HALT_S;
        else if (step_req) state_d = (step_cnt != '0) ? STEP_S : HALT_S;
        else if (run_req) state_d = RUN_S;
      end
      STEP_S: begin
        if (halt_req) state_d = HALT_S;
        else if (match) begin
          state_d = HALT_S;
          bp_hit_d = 1'b1;
        end
        else if (retire && rem_q == STEP_W'(1)) state_d = HALT_S;
        else if (run_req) state_d = RUN_S;
      end
      default: state_d = RST_S;
    endcase
    rem_d = (state_d != STEP_S) ? '0 : (state_q == HALT_S) ? step_cnt : rem_q - STEP_W'(retire);
    resume = (state_q == HALT_S) && (state_d != HALT_S);
    cycle_d = cycle_q + CNT_W'(!freeze_q);
    retire_d = retire_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_S;
      freeze_q <= START_HALTED;
      bp_hit_q <= 1'b0;
      rem_q    <= '0;
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      freeze_q <= (state_d == HALT_S);
      bp_hit_q <= bp_hit_d;
      rem_q    <= rem_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
    end
  end
  assign freeze = freeze_q;
  assign halted = freeze_q;
  assign state = state_q;
  assign bp_hit = bp_hit_q;
  assign cycle_cnt = cycle_q;
  assign retire_cnt = retire_q;
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: directed self-checking bench for the run/halt/step controller
module tb_pipe_run_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic run_req = 0, halt_req = 0, step_req = 0, bp_en = 0, wb_valid = 0;
  logic [7:0] step_cnt = 0;
  logic [31:0] bp_addr = 32'h10, if_pc = 32'h100;
  logic freeze, halted, bp_hit;
  logic [1:0] state;
  logic [31:0] cycle_cnt, retire_cnt;
  int errs = 0, checks = 0;

  pipe_run_ctrl #(.STEP_W(8), .START_HALTED(1'b1)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc), .wb_valid(wb_valid),
    .freeze(freeze), .halted(halted), .state(state), .bp_hit(bp_hit),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    run_req = 0; halt_req = 0; step_req = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'b01) begin errs++; $display("FAIL reset_state: got %b want 01", state); end
    checks++; if (freeze !== 1'b1 || halted !== 1'b1) begin errs++; $display("FAIL reset_freeze: got %b/%b want 1/1", freeze, halted); end
    checks++; if (bp_hit !== 1'b0) begin errs++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit); end
    checks++; if (cycle_cnt !== 0 || retire_cnt !== 0) begin errs++; $display("FAIL reset_cnt: got %h/%h want 0/0", cycle_cnt, retire_cnt); end
    rst = 0;
    wb_valid = 1;
    repeat (20) tick();
    wb_valid = 0;
    checks++; if (state !== 2'b01 || freeze !== 1'b1) begin errs++; $display("FAIL halted_idle: got %b/%b want 01/1", state, freeze); end
    checks++; if (cycle_cnt !== 0 || retire_cnt !== 0) begin errs++; $display("FAIL halted_cnt: got %h/%h want 0/0", cycle_cnt, retire_cnt); end
  endtask

  task automatic test_run();
    run_req = 1;
    tick();
    checks++; if (state !== 2'b00 || freeze !== 1'b0) begin errs++; $display("FAIL run_start: got %b/%b want 00/0", state, freeze); end
    checks++; if (cycle_cnt !== 0) begin errs++; $display("FAIL run_cnt0: got %0d want 0", cycle_cnt); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (cycle_cnt !== 32'(i)) begin errs++; $display("FAIL run_cnt: got %0d want %0d", cycle_cnt, i); end
    end
    halt_req = 1;
    tick();
    checks++; if (state !== 2'b01 || freeze !== 1'b1) begin errs++; $display("FAIL halt_req: got %b/%b want 01/1", state, freeze); end
    tick();
    checks++; if (cycle_cnt !== 4) begin errs++; $display("FAIL halt_cnt: got %0d want 4", cycle_cnt); end
  endtask

  task automatic test_step();
    step_cnt = 3; step_req = 1;
    tick();
    checks++; if (state !== 2'b10 || freeze !== 1'b0) begin errs++; $display("FAIL step_enter: got %b/%b want 10/0", state, freeze); end
    wb_valid = 1; tick();
    wb_valid = 0; tick();
    wb_valid = 1; tick();
    checks++; if (retire_cnt !== 2 || state !== 2'b10) begin errs++; $display("FAIL step_mid: got %0d/%b want 2/10", retire_cnt, state); end
    tick();
    checks++; if (retire_cnt !== 3 || state !== 2'b01 || freeze !== 1'b1) begin errs++; $display("FAIL step_done: got %0d/%b/%b want 3/01/1", retire_cnt, state, freeze); end
    tick();
    wb_valid = 0;
    checks++; if (retire_cnt !== 3 || cycle_cnt !== 8) begin errs++; $display("FAIL step_after: got %0d/%0d want 3/8", retire_cnt, cycle_cnt); end
  endtask

  task automatic test_breakpoint();
    bp_en = 1; bp_addr = 32'h10; if_pc = 32'h0C; run_req = 1;
    tick();
    tick();
    checks++; if (state !== 2'b00 || bp_hit !== 1'b0) begin errs++; $display("FAIL bp_pre: got %b/%b want 00/0", state, bp_hit); end
    if_pc = 32'h10;
    tick();
    checks++; if (state !== 2'b01 || bp_hit !== 1'b1) begin errs++; $display("FAIL bp_hit1: got %b/%b want 01/1", state, bp_hit); end
    tick();
    checks++; if (bp_hit !== 1'b0 || state !== 2'b01) begin errs++; $display("FAIL bp_pulse: got %b/%b want 0/01", bp_hit, state); end
    run_req = 1;
    tick();
    tick();
    tick();
    checks++; if (state !== 2'b00 || bp_hit !== 1'b0) begin errs++; $display("FAIL bp_rehit: got %b/%b want 00/0", state, bp_hit); end
    if_pc = 32'h14; tick();
    checks++; if (state !== 2'b00) begin errs++; $display("FAIL bp_move: got %b want 00", state); end
    if_pc = 32'h10; tick();
    checks++; if (state !== 2'b01 || bp_hit !== 1'b1) begin errs++; $display("FAIL bp_hit2: got %b/%b want 01/1", state, bp_hit); end
    bp_en = 0; if_pc = 32'h100;
    tick();
  endtask

  task automatic test_priority();
    halt_req = 1; step_req = 1; run_req = 1; step_cnt = 3;
    tick();
    checks++; if (state !== 2'b01 || freeze !== 1'b1) begin errs++; $display("FAIL prio_all: got %b/%b want 01/1", state, freeze); end
    step_req = 1; step_cnt = 0;
    tick();
    checks++; if (state !== 2'b01 || dut.rem_q !== 8'd0) begin errs++; $display("FAIL step_zero: got %b/%0d want 01/0", state, dut.rem_q); end
  endtask

  task automatic test_rst_mid_step();
    step_cnt = 5; step_req = 1;
    tick();
    wb_valid = 1;
    tick();
    tick();
    checks++; if (retire_cnt !== 5 || dut.rem_q !== 8'd3 || state !== 2'b10) begin errs++; $display("FAIL mid_step: got %0d/%0d/%b want 5/3/10", retire_cnt, dut.rem_q, state); end
    #2 rst = 1;
    #1;
    checks++; if (state !== 2'b01 || freeze !== 1'b1 || bp_hit !== 1'b0) begin errs++; $display("FAIL async_rst: got %b/%b/%b want 01/1/0", state, freeze, bp_hit); end
    checks++; if (cycle_cnt !== 0 || retire_cnt !== 0 || dut.rem_q !== 8'd0) begin errs++; $display("FAIL async_rst_cnt: got %h/%h/%0d want 0/0/0", cycle_cnt, retire_cnt, dut.rem_q); end
    wb_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_wrap();
    run_req = 1;
    tick();
    force dut.cycle_q = 32'hFFFF_FFFF;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    release dut.retire_q;
    wb_valid = 1;
    #1;
    checks++; if (cycle_cnt !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_preload: got %h want ffffffff", cycle_cnt); end
    tick();
    checks++; if (cycle_cnt !== 0 || retire_cnt !== 0) begin errs++; $display("FAIL wrap: got %h/%h want 0/0", cycle_cnt, retire_cnt); end
    tick();
    checks++; if (cycle_cnt !== 1 || retire_cnt !== 1) begin errs++; $display("FAIL wrap_next: got %h/%h want 1/1", cycle_cnt, retire_cnt); end
    wb_valid = 0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_priority();
    test_rst_mid_step();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Run/halt/step controller for the 5-stage MIPS pipeline.
- Drives one global freeze that holds the PC, all four pipeline registers and the register-file/data-memory write enables. Freeze is ORed with the hazard unit's Stall_IF/Stall_ID by the top level.
- Supports free run, halt on request, N-instruction single-step, one PC breakpoint, and cycle/retire counters for the board display.

Parameters:
- STEP_W, 8, width of the step-count request.
- START_HALTED, 0, 1 = leave reset in HALT, 0 = leave reset in RUN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- run_req  in  1  one-cycle pulse: resume free run
- halt_req  in  1  one-cycle pulse: stop the pipeline
- step_req  in  1  one-cycle pulse: retire step_cnt instructions, then halt
- step_cnt  in  STEP_W  number of instructions to retire; sampled with step_req
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- if_pc  in  32  PC currently presented to instruction memory
- wb_valid  in  1  a real (non-bubble) instruction is in MEM/WB this cycle
- freeze  out  1  registered; 1 = hold all pipeline state
- halted  out  1  registered; state == HALT
- state  out  2  00 RUN, 01 HALT, 10 STEP
- bp_hit  out  1  one-cycle pulse, registered, on breakpoint halt
- cycle_cnt  out  32  clocks spent with freeze == 0
- retire_cnt  out  32  instructions retired (wb_valid && !freeze)

Behaviour:
- Reset (async, rst = 1): state = START_HALTED ? HALT : RUN; freeze = halted = START_HALTED; bp_hit = 0; cycle_cnt = retire_cnt = 0; step remaining = 0; bp_armed = 1.
- Outputs freeze, halted and state are registered from next-state, so no combinational path runs from request inputs to freeze.
- Retire event: an edge with freeze == 0 && wb_valid == 1. retire_cnt increments by 1 on each retire event.
- cycle_cnt increments by 1 on every edge with freeze == 0.
- Both counters wrap 0xFFFFFFFF -> 0.
- Request priority when pulses coincide: halt_req > step_req > run_req.
- RUN:
  - halt_req -> HALT.
  - Breakpoint match (bp_en && bp_armed && if_pc == bp_addr) -> HALT with bp_hit = 1 for one cycle. The matching instruction is latched into IF/ID but not executed.
  - step_req is ignored; run_req is a no-op.
- HALT:
  - run_req -> RUN.
  - step_req with step_cnt != 0 -> STEP, remaining = step_cnt.
  - step_req with step_cnt == 0 is ignored and the block stays in HALT.
- STEP:
  - Each retire event decrements remaining.
  - A retire event while remaining == 1 -> HALT. freeze goes high after that same edge, so exactly step_cnt instructions retire.
  - halt_req aborts to HALT; remaining is discarded.
  - run_req -> RUN.
  - A breakpoint match -> HALT with bp_hit.
  - Bubbles (wb_valid = 0) do not count.
- Breakpoint re-arm:
  - Leaving HALT clears bp_armed, so resuming from a breakpoint does not re-trigger on the same PC.
  - bp_armed sets again the first cycle that if_pc != bp_addr.
  - Hazard stalls that hold if_pc at bp_addr keep bp_armed low.
  - bp_en = 0 disables matching; bp_armed still tracks if_pc.
- rst asserted mid-STEP clears remaining and counters immediately.
- freeze is asserted while halted; the display path stays live.

Decomposition:
- Shared package pipe_dbg_pkg:
  - state encodings RUN_S = 2'b00, HALT_S = 2'b01, STEP_S = 2'b10.
  - STEP_W default.
  - counter width constant CNT_W = 32.
- One natural sub-module, pipe_bp_match: comparator plus bp_armed flag.
  - Inputs: clk, rst, bp_en, bp_addr, if_pc, resume (pulse on leaving HALT).
  - Output: match.
- FSM and counters stay in pipe_run_ctrl.

Test Plan:
- START_HALTED = 1, release rst -> freeze = 1, state = 01, cycle_cnt stays 0 for 20 cycles; run_req -> freeze = 0 one cycle later, cycle_cnt counts 1, 2, 3, ….
- HALT, step_cnt = 3, step_req; wb_valid pattern 1, 0, 1, 1 -> retire_cnt +3, state returns to 01 on the edge of the third retire, freeze = 1 the following cycle.
- RUN, bp_en = 1, bp_addr = 0x10, if_pc sweeps 0x0C, 0x10 -> bp_hit pulses once, state = 01; run_req with if_pc held at 0x10 for 2 stall cycles -> no re-hit; later if_pc 0x14 then loop back to 0x10 -> second hit.
- Same-cycle halt_req + step_req + run_req in HALT -> stays HALT; step_req with step_cnt = 0 -> stays HALT, remaining = 0.
- STEP with remaining = 5, assert rst after 2 retires -> immediately state = START_HALTED value, counters = 0, bp_hit = 0.
- Force cycle_cnt to 0xFFFFFFFF in RUN (preload via backdoor) -> next edge reads 0x00000000; retire_cnt checked likewise.
